// File: rtl/dc_buffer_arbiter_ctrl.sv
// dc_buffer_arbiter_ctrl: shares one dc_data_buffer between two round-robin
// arbitrated write requesters and a single valid/ready reader. Drives one-hot
// write/read pointers; the buffer head returns combinationally as out_data.
module dc_buffer_arbiter_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    in0_valid,
  input  logic [DATA_WIDTH-1:0]   in0_data,
  output logic                    in0_ready,
  input  logic                    in1_valid,
  input  logic [DATA_WIDTH-1:0]   in1_data,
  output logic                    in1_ready,
  output logic [BUFFER_DEPTH-1:0] write_pointer,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [BUFFER_DEPTH-1:0] read_pointer,
  input  logic [DATA_WIDTH-1:0]   read_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    count,
  output logic                    full,
  output logic                    empty
);

  // Usable capacity is one less than the slot count so the write pointer
  // (which the buffer writes through every cycle) never lands on unread data.
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(BUFFER_DEPTH - 1);

  logic prio;     // 0: in0 preferred on contention, 1: in1 preferred
  logic grant0, grant1, push, pop;

  // Occupancy flags, arbitration and handshake decode
  always_comb begin
    full      = (count == CAP);
    empty     = (count == '0);
    grant0    = ~full & in0_valid & (~prio | ~in1_valid);
    grant1    = ~full & in1_valid & ( prio | ~in0_valid);
    in0_ready = grant0;
    in1_ready = grant1;
    push      = grant0 | grant1;
    out_valid = ~empty;
    pop       = out_valid & out_ready;
    write_data = grant1 ? in1_data : in0_data;
    out_data  = read_data;
  end

  // Pointer rotation, occupancy count and priority; flush reloads reset state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_pointer <= BUFFER_DEPTH'(1);
      read_pointer  <= BUFFER_DEPTH'(1);
      count         <= '0;
      prio          <= 1'b0;
    end else if (flush) begin
      write_pointer <= BUFFER_DEPTH'(1);
      read_pointer  <= BUFFER_DEPTH'(1);
      count         <= '0;
      prio          <= 1'b0;
    end else begin
      if (push) begin
        write_pointer <= {write_pointer[BUFFER_DEPTH-2:0], write_pointer[BUFFER_DEPTH-1]};
        // The loser of this grant gets preference next time
        prio          <= grant0;
      end
      if (pop)
        read_pointer <= {read_pointer[BUFFER_DEPTH-2:0], read_pointer[BUFFER_DEPTH-1]};
      if (push && !pop)
        count <= count + CNT_WIDTH'(1);
      else if (pop && !push)
        count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/dc_buffer_arbiter_ctrl.md
# dc_buffer_arbiter_ctrl

Single-clock controller that shares one `dc_data_buffer` instance between two write requesters and one reader. It round-robin arbitrates the two valid/ready input streams and muxes the granted data onto the buffer write port. It drives the one-hot write/read pointers and presents the buffer head to the consumer over a valid/ready handshake. It sits directly beside the buffer; `read_data` from the buffer returns through this block as `out_data`.

## Interface
- `DATA_WIDTH`, 32, payload width; must match the buffer.
- `BUFFER_DEPTH`, 8, buffer slots (≥2); usable capacity is `BUFFER_DEPTH-1`.
- `CNT_WIDTH`, `log2(BUFFER_DEPTH)+1`, width of `count`.

- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of pointers, count and priority.
- `in0_valid`, `in1_valid`  in  1 each  requester has a beat.
- `in0_data`, `in1_data`  in  DATA_WIDTH each  requester payload.
- `in0_ready`, `in1_ready`  out  1 each  beat accepted this cycle when valid&ready.
- `write_pointer`  out  BUFFER_DEPTH  one-hot slot to the buffer write port.
- `write_data`  out  DATA_WIDTH  muxed payload to the buffer.
- `read_pointer`  out  BUFFER_DEPTH  one-hot slot to the buffer read port.
- `read_data`  in  DATA_WIDTH  buffer output.
- `out_valid`  out  1  head entry available.
- `out_data`  out  DATA_WIDTH  equals `read_data`.
- `out_ready`  in  1  consumer accepts head.
- `count`  out  CNT_WIDTH  occupied slots.
- `full`, `empty`  out  1 each  `count==BUFFER_DEPTH-1`, `count==0`.

## Operation
- Pointers are always exactly one-hot and never zero. The buffer writes `write_data` into `write_pointer`'s slot every cycle, so `write_pointer` always addresses the next free slot. Capacity is held at `BUFFER_DEPTH-1` so that `write_pointer` never equals `read_pointer` while data is stored. This guarantees that an unused write never clobbers unread data.
- Arbitration uses a 1-bit priority register `prio` (0 = in0 preferred).
  - grant0 = ~full & in0_valid & (prio==0 | ~in1_valid).
  - grant1 = ~full & in1_valid & (prio==1 | ~in0_valid).
  - `inN_ready` = grantN. At most one grant per cycle.
- `write_data` = in1_data if grant1, else in0_data.
- On a push (any grant), `write_pointer` rotates left by 1 (MSB wraps to bit 0), and `prio` becomes the index of the non-granted requester.
- On a pop (`out_valid & out_ready`), `read_pointer` rotates left by 1.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_valid` = ~empty. `out_data` is passed through combinationally.
- Push readiness does not depend on `out_ready`. When full, no push is accepted even if a pop occurs in the same cycle.
- `flush` overrides push and pop in that cycle. It loads the reset values. Data in the buffer is left untouched but becomes unreachable.

## Timing
- Reset values: write_pointer = read_pointer = 1 (bit 0), count = 0, prio = 0, empty = 1, full = 0, out_valid = 0. `inN_ready` follows the grant equations, so in0_ready = in0_valid after reset.
- Ready depends combinationally on valid and state only, never on other ready signals.
- Latency: a beat accepted at edge N is visible as `out_valid`/`out_data` after edge N; it can pop at edge N+1.
- Throughput: one push and one pop per cycle sustained. With both requesters continuously valid, grants alternate every cycle.
- Wrap: after BUFFER_DEPTH pushes, `write_pointer` returns to bit 0. `read_pointer` wraps in the same way.
- Asserting `rstn` low mid-transfer takes effect immediately: outputs go to their reset values without waiting for a clock edge.

## Test plan
- Reset: drive rstn=0, then release with in0_valid=1 → write_pointer=8'h01, read_pointer=8'h01, out_valid=0, in0_ready=1, count=0.
- Single beat: in0 pushes 32'hA5A5_0001 → next cycle out_valid=1, out_data=32'hA5A5_0001, count=1. Pop it → empty=1, read_pointer=8'h02.
- Fill: push 7 beats with no pops → full=1 after the 7th, count=7, in0_ready=in1_ready=0, write_pointer=8'h80. Head data is intact.
- Round robin: both requesters valid, out_ready=1 for 6 cycles → accepted order in0,in1,in0,in1,in0,in1. Outputs match that order.
- Wrap and concurrency: push and pop in the same cycle for 20 cycles at count=3 → count stays 3, pointers wrap through 8'h80→8'h01, data order is preserved.
- Flush with count=5 → next cycle count=0, both pointers 8'h01, out_valid=0, prio=0.
